// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR constants, tap positions and decoder FSM states
package lfsr_pkg;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h9C;
  localparam int TAP_A = 7;
  localparam int TAP_B = 5;
  localparam int TAP_C = 4;
  localparam int TAP_D = 3;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;
endpackage

// File: rtl/lfsr_next.sv
// lfsr_next: one LFSR step; a zero result is replaced by SEED (ports: s_i current, next_o successor)
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
  input  logic [LFSR_W-1:0] s_i,
  output logic [LFSR_W-1:0] next_o
);
  logic fb;
  logic [LFSR_W-1:0] raw;
  assign fb = s_i[TAP_A] ^ s_i[TAP_B] ^ s_i[TAP_C] ^ s_i[TAP_D];
  assign raw = {fb, s_i[LFSR_W-1:1]};
  assign next_o = (raw == '0) ? SEED : raw;
endmodule

// File: rtl/lfsr_decoder.sv
// lfsr_decoder: replays the LFSR from SEED to find the step index of target (ports: clk, reset, start, target in; busy, done, index, err out; option LFSR_DEC_ZERO_CHK_EN)
module lfsr_decoder
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED,
  parameter int MAX_STEPS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LFSR_W-1:0] target,
  output logic              busy,
  output logic              done,
  output logic [LFSR_W-1:0] index,
  output logic              err
);
  state_e state_q;
  logic [LFSR_W-1:0] target_q, cur_q, cur_d, index_q;
  logic [8:0] cnt_q;
  logic busy_q, done_q, err_q;
`ifdef LFSR_DEC_ZERO_CHK_EN
  logic zero_q;
`endif
  lfsr_next #(.SEED(SEED)) u_next (.s_i(cur_q), .next_o(cur_d));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      index_q  <= '0;
      cnt_q    <= '0;
      cur_q    <= SEED;
      target_q <= '0;
`ifdef LFSR_DEC_ZERO_CHK_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            target_q <= target;
            cur_q    <= SEED;
            cnt_q    <= '0;
`ifdef LFSR_DEC_ZERO_CHK_EN
            // zero is never generated: skip the search and report in the DONE exit cycle
            if (target == '0) begin
              state_q <= DONE;
              zero_q  <= 1'b1;
              index_q <= '1;
              err_q   <= 1'b1;
            end else begin
              state_q <= SEARCH;
              busy_q  <= 1'b1;
            end
`else
            state_q <= SEARCH;
            busy_q  <= 1'b1;
`endif
          end
        end
        SEARCH: begin
          if (cur_q == target_q) begin
            index_q <= cnt_q[LFSR_W-1:0];
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (cnt_q == 9'(MAX_STEPS - 1)) begin
            index_q <= '1;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cur_q <= cur_d;
            cnt_q <= cnt_q + 9'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
`ifdef LFSR_DEC_ZERO_CHK_EN
          if (zero_q) begin
            done_q <= 1'b1;
            zero_q <= 1'b0;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy  = busy_q;
  assign done  = done_q;
  assign index = index_q;
  assign err   = err_q;
endmodule

// File: tb/tb_lfsr_decoder.sv
// tb_lfsr_decoder: table-driven and directed checks of lfsr_decoder
module tb_lfsr_decoder;
  logic clk = 1'b0;
  logic reset, start, busy, done, err;
  logic [7:0] target, index;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [7:0] t;
    logic [7:0] idx;
    logic       e;
    int         cyc;
  } vec_t;
  vec_t vecs[7];
  lfsr_decoder dut (
    .clk(clk), .reset(reset), .start(start), .target(target),
    .busy(busy), .done(done), .index(index), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run(input logic [7:0] t, output int cyc, output bit got, output bit busy1, output bit overlap);
    @(negedge clk);
    start = 1'b1;
    target = t;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy1 = busy;
    overlap = 1'b0;
    while (!done && cyc < 400) begin
      if (busy && done) overlap = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (busy && done) overlap = 1'b1;
    got = done;
  endtask
  initial begin
    int cyc, pulses;
    bit got, b1, ov;
    vecs[0] = '{8'h9C, 8'h00, 1'b0, 2};
    vecs[1] = '{8'hCE, 8'h01, 1'b0, 3};
    vecs[2] = '{8'h67, 8'h02, 1'b0, 4};
    vecs[3] = '{8'hD9, 8'h04, 1'b0, 6};
    vecs[4] = '{8'hEC, 8'h05, 1'b0, 7};
`ifdef LFSR_DEC_ZERO_CHK_EN
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 2};
`else
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 257};
`endif
    vecs[6] = '{8'hB3, 8'h03, 1'b0, 5};
    reset = 1'b1;
    start = 1'b0;
    target = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_index", index, 0);
      check("rst_err", err, 0);
    end
    for (int i = 0; i < 7; i++) begin
      run(vecs[i].t, cyc, got, b1, ov);
      check($sformatf("v%0d_done_seen", i), got, 1);
      check($sformatf("v%0d_done_cycle", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d_index", i), index, vecs[i].idx);
      check($sformatf("v%0d_err", i), err, vecs[i].e);
      check($sformatf("v%0d_busy_done_overlap", i), ov, 0);
      if (vecs[i].cyc > 2 || vecs[i].e == 1'b0) check($sformatf("v%0d_busy_c1", i), b1, 1);
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", i), done, 0);
      check($sformatf("v%0d_index_held", i), index, vecs[i].idx);
    end
    // back-to-back: start again right after the B3 result
    run(8'hCE, cyc, got, b1, ov);
    check("b2b_cycle", cyc, 3);
    check("b2b_index", index, 1);
    // reset during a search for 67
    @(negedge clk);
    start = 1'b1;
    target = 8'h67;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_index", index, 0);
    check("midrst_err", err, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", pulses, 0);
    run(8'h67, cyc, got, b1, ov);
    check("midrst_restart_cycle", cyc, 4);
    check("midrst_restart_index", index, 2);
    // second start while busy is ignored
    @(negedge clk);
    start = 1'b1;
    target = 8'hB3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    target = 8'hCE;
    @(negedge clk);
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("ign_cycle", cyc, 5);
    check("ign_index", index, 3);
    check("ign_err", err, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("ign_no_second_done", pulses, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lfsr_decoder.md
# lfsr_decoder

Sequence-index recovery block for the 8-bit button-stepped LFSR.
- Given an observed LFSR value, it replays the generator's sequence from the fixed seed and reports how many steps separate the seed from that value.
- It reports an error if the value is unreachable.
- It sits beside the generator in the lab6 datapath: it takes a latched display value, and the index it returns feeds the score/step readout.

## Interface
Parameters:
- SEED, 8'h9C, power-on value of the generator; index 0
- MAX_STEPS, 256, compare cycles before declaring unreachable

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; honoured only in IDLE
- target  in  8  value to locate; sampled on accepted start
- busy  out  1  high while a search is in progress
- done  out  1  one-cycle pulse; index/err valid in this cycle and held until next start
- index  out  8  step count from SEED to target
- err  out  1  target unreachable (valid with done)

## Operation
Step function, identical to the generator:
- fb = s[7]^s[5]^s[4]^s[3]
- next = {fb, s[7:1]}
- if next == 0, next = SEED

FSM states IDLE, SEARCH, DONE:
- IDLE: on start, latch target_q <= target, cur <= SEED, cnt <= 0, go to SEARCH. start while busy is ignored.
- SEARCH, compare each cycle:
  - cur == target_q: index <= cnt, err <= 0, go to DONE.
  - Else cnt == MAX_STEPS-1: index <= 8'hFF, err <= 1, go to DONE.
  - Else cur <= next(cur), cnt <= cnt+1.
- DONE: done = 1 for exactly one cycle, then IDLE. start in DONE is ignored.
- cnt is 9 bits internally; index is cnt[7:0].
- Mismatches through 256 compares mean unreachable; the step function is not invertible, so the sequence may cycle without revisiting SEED.
- Zero is never produced by the step function, so target 0 is always unreachable.

## Timing
- Reset values: busy=0, done=0, index=8'h00, err=0, state IDLE.
- start accepted at cycle 0: busy=1 from cycle 1; the compare for index k occurs in cycle k+1; done=1 in cycle k+2; busy=0 in cycle k+2.
- Unreachable target: done in cycle MAX_STEPS+1 (257) with err=1, index=8'hFF.
- busy and done are never both high.
- Reset asserted mid-search: next cycle is IDLE with all outputs at reset values, and no done pulse.
- Reset and start in the same cycle: reset wins.

## Configuration
LFSR_DEC_ZERO_CHK_EN:
- Defined: start with target==0 skips SEARCH and goes IDLE→DONE. done and err=1 in cycle 2 (cycle 1 is DONE), index=8'hFF.
- Undefined: a zero target performs the full search, and done/err=1 arrives in cycle 257.

## Structure
Package lfsr_pkg:
- LFSR_SEED (8'h9C)
- LFSR_W (8)
- tap indices 7,5,4,3
- state enum {IDLE, SEARCH, DONE}

Sub-module lfsr_next:
- Combinational step function including the zero guard.
- Shared with the generator so both ends cannot diverge.

## Test plan
- After reset, no start → busy=0, done=0, index=00, err=0 held for 10 cycles.
- start, target=8'h9C → done in cycle 2, index=0, err=0.
- start, target=8'hB3 → done in cycle 5, index=3, err=0; a back-to-back start with target=8'hCE → index=1.
- start, target=8'h00:
  - LFSR_DEC_ZERO_CHK_EN defined → done+err in cycle 2.
  - Undefined → done+err in cycle 257, index=FF.
- start target=8'h67, assert reset in cycle 2 → no done pulse, outputs reset; a new start then yields index=2.
- Second start pulsed while busy → ignored; the single done reflects the first target only.
